// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared types and constants for Pac-Man motion control and the sprite
// renderer: direction encoding, FSM states, tile geometry and the
// opposite-direction helper.
// -----------------------------------------------------------------------------
package pacman_pkg;

    // Joystick and facing direction, shared with the renderer.
    typedef enum logic [1:0] {
        DIR_RT = 2'b00,
        DIR_UP = 2'b01,
        DIR_DN = 2'b10,
        DIR_LT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURN_PROBE,
        ST_FWD_PROBE,
        ST_MOVE,
        ST_DYING,
        ST_OVER
    } state_t;

    // Tiles are 8x8 px; a sprite is centred in a tile when its low bits equal 4.
    localparam int         TILE_SHIFT = 3;
    localparam logic [2:0] ALIGN_OFS  = 3'd4;

    // The encoding pairs opposites as bitwise complements (RT<->LT, UP<->DN).
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/pacman_probe_if.sv
// -----------------------------------------------------------------------------
// pacman_probe_if
// Valid/ready tile query from the motion controller (master) to the maze
// tile ROM (slave).
//   probe_valid  master->slave  query valid
//   probe_tx     master->slave  tile column
//   probe_ty     master->slave  tile row
//   probe_ready  slave->master  query accepted this cycle
//   probe_wall   slave->master  wall flag, valid with probe_valid & probe_ready
// -----------------------------------------------------------------------------
interface pacman_probe_if;
    logic       probe_valid;
    logic [4:0] probe_tx;
    logic [4:0] probe_ty;
    logic       probe_ready;
    logic       probe_wall;

    modport master (
        output probe_valid, probe_tx, probe_ty,
        input  probe_ready, probe_wall
    );

    modport slave (
        input  probe_valid, probe_tx, probe_ty,
        output probe_ready, probe_wall
    );
endinterface

// File: rtl/pacman_anim_ctr.sv
// -----------------------------------------------------------------------------
// pacman_anim_ctr
// Mouth animation: divides moves by ANIM_DIV and walks a 2-bit phase whose
// displayed frame follows 0,1,2,1.
//   clk, rst_n       clock, async active-low reset
//   step             one move completed this cycle
//   clear            restart at frame 0 (death / respawn); wins over step
//   animation_cycle  sprite frame index 0..2
// With step low the counter holds.
// -----------------------------------------------------------------------------
module pacman_anim_ctr #(
    parameter int ANIM_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       clear,
    output logic [1:0] animation_cycle
);

    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [CW-1:0] move_cnt_q;
    logic [1:0]    phase_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt_q <= '0;
            phase_q    <= '0;
        end else if (clear) begin
            move_cnt_q <= '0;
            phase_q    <= '0;
        end else if (step) begin
            if (move_cnt_q == CW'(ANIM_DIV - 1)) begin
                move_cnt_q <= '0;
                phase_q    <= phase_q + 2'd1;
            end else begin
                move_cnt_q <= move_cnt_q + 1'b1;
            end
        end
    end

    // Phase 3 re-shows frame 1 so the mouth closes smoothly.
    assign animation_cycle = (phase_q == 2'd3) ? 2'd1 : phase_q;

endmodule

// File: rtl/pacman_motion.sv
// -----------------------------------------------------------------------------
// pacman_motion
// Per-frame Pac-Man movement controller feeding the sprite renderer.
//   clk, rst_n       clock, async active-low reset
//   frame_tick       one-cycle pulse per frame (vertical blank)
//   req_valid/dir    joystick request strobe / direction (buffered)
//   kill             ghost-collision pulse
//   probe            tile ROM query port (master side)
//   xloc, yloc       sprite centre in px
//   pacman_dir       facing direction
//   pacman_alive     1 while playing, 0 while dying or game over
//   animation_cycle  mouth frame 0..2
//   lives_left       remaining lives
//   game_over        sticky end-of-game flag
// -----------------------------------------------------------------------------
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int START_X      = 116,
    parameter int START_Y      = 188,
    parameter int MAZE_W       = 224,
    parameter int COLS         = 28,
    parameter int ANIM_DIV     = 2,
    parameter int DEATH_FRAMES = 90,
    parameter int LIVES        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  req_valid,
    input  dir_t                  req_dir,
    input  logic                  kill,
    pacman_probe_if.master        probe,
    output logic [8:0]            xloc,
    output logic [8:0]            yloc,
    output dir_t                  pacman_dir,
    output logic                  pacman_alive,
    output logic [1:0]            animation_cycle,
    output logic [1:0]            lives_left,
    output logic                  game_over
);

    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    state_t        state_q, state_n;
    logic [8:0]    x_q, x_n, y_q, y_n;
    dir_t          dir_q, dir_n;
    dir_t          req_q, req_n;
    dir_t          turn_q, turn_n;     // request under test, frozen for the probe
    logic [1:0]    lives_q, lives_n;
    logic          alive_q, alive_n;
    logic          over_q, over_n;
    logic [DW-1:0] death_q, death_n;

    logic          aligned, probe_active, accept;
    logic          anim_step, anim_clear;
    dir_t          probe_dir;
    logic [4:0]    tile_x, tile_y, ahead_tx, ahead_ty;

    assign aligned = (x_q[2:0] == ALIGN_OFS) && (y_q[2:0] == ALIGN_OFS);
    assign tile_x  = x_q[TILE_SHIFT +: 5];
    assign tile_y  = y_q[TILE_SHIFT +: 5];

    // Probe outputs decode straight from registered state, so they hold
    // steady through a stall and drop asynchronously with reset.
    assign probe_active = (state_q == ST_TURN_PROBE) ||
                          (state_q == ST_FWD_PROBE && aligned);
    assign probe_dir    = (state_q == ST_TURN_PROBE) ? turn_q : dir_q;
    assign accept       = probe_active && probe.probe_ready;

    // Ahead tile: columns wrap through the tunnel, rows clamp.
    always_comb begin
        ahead_tx = tile_x;
        ahead_ty = tile_y;
        unique case (probe_dir)
            DIR_RT: ahead_tx = (tile_x == 5'(COLS - 1)) ? 5'd0 : tile_x + 5'd1;
            DIR_LT: ahead_tx = (tile_x == 5'd0) ? 5'(COLS - 1) : tile_x - 5'd1;
            DIR_UP: ahead_ty = (tile_y == 5'd0) ? 5'd0 : tile_y - 5'd1;
            DIR_DN: ahead_ty = (tile_y == 5'd31) ? 5'd31 : tile_y + 5'd1;
        endcase
    end

    assign probe.probe_valid = probe_active;
    assign probe.probe_tx    = probe_active ? ahead_tx : 5'd0;
    assign probe.probe_ty    = probe_active ? ahead_ty : 5'd0;

    // NOTE: every variable driven here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state_q;
        x_n        = x_q;
        y_n        = y_q;
        dir_n      = dir_q;
        req_n      = req_q;
        turn_n     = turn_q;
        lives_n    = lives_q;
        alive_n    = alive_q;
        over_n     = over_q;
        death_n    = death_q;
        anim_step  = 1'b0;
        anim_clear = 1'b0;

        if (req_valid && state_q != ST_OVER) begin
            req_n = req_dir;
        end

        if (kill && (state_q == ST_IDLE || state_q == ST_TURN_PROBE ||
                     state_q == ST_FWD_PROBE || state_q == ST_MOVE)) begin
            // Abort the frame; position and direction freeze where they are.
            state_n    = ST_DYING;
            alive_n    = 1'b0;
            lives_n    = lives_q - 2'd1;
            death_n    = '0;
            anim_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        if (req_q == opposite(dir_q)) begin
                            dir_n   = req_q;        // reversal needs no probe
                            state_n = ST_FWD_PROBE;
                        end else if (aligned && req_q != dir_q) begin
                            turn_n  = req_q;
                            state_n = ST_TURN_PROBE;
                        end else begin
                            state_n = ST_FWD_PROBE;
                        end
                    end
                end
                ST_TURN_PROBE: begin
                    if (accept) begin
                        if (!probe.probe_wall) dir_n = turn_q;
                        state_n = ST_FWD_PROBE;
                    end
                end
                ST_FWD_PROBE: begin
                    if (!aligned) begin
                        state_n = ST_MOVE;
                    end else if (accept) begin
                        state_n = probe.probe_wall ? ST_IDLE : ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    unique case (dir_q)
                        DIR_RT: x_n = (x_q == 9'(MAZE_W - 1)) ? 9'd0 : x_q + 9'd1;
                        DIR_LT: x_n = (x_q == 9'd0) ? 9'(MAZE_W - 1) : x_q - 9'd1;
                        DIR_UP: y_n = y_q - 9'd1;
                        DIR_DN: y_n = y_q + 9'd1;
                    endcase
                    anim_step = 1'b1;
                    state_n   = ST_IDLE;
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (death_q == DW'(DEATH_FRAMES - 1)) begin
                            if (lives_q == 2'd0) begin
                                over_n  = 1'b1;
                                state_n = ST_OVER;
                            end else begin
                                x_n        = 9'(START_X);
                                y_n        = 9'(START_Y);
                                dir_n      = DIR_LT;
                                req_n      = DIR_LT;
                                anim_clear = 1'b1;
                                alive_n    = 1'b1;
                                state_n    = ST_IDLE;
                            end
                        end else begin
                            death_n = death_q + 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    over_n  = 1'b1;
                    alive_n = 1'b0;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 9'(START_X);
            y_q     <= 9'(START_Y);
            dir_q   <= DIR_LT;
            req_q   <= DIR_LT;
            turn_q  <= DIR_LT;
            lives_q <= 2'(LIVES);
            alive_q <= 1'b1;
            over_q  <= 1'b0;
            death_q <= '0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            dir_q   <= dir_n;
            req_q   <= req_n;
            turn_q  <= turn_n;
            lives_q <= lives_n;
            alive_q <= alive_n;
            over_q  <= over_n;
            death_q <= death_n;
        end
    end

    pacman_anim_ctr #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk             (clk),
        .rst_n           (rst_n),
        .step            (anim_step),
        .clear           (anim_clear),
        .animation_cycle (animation_cycle)
    );

    assign xloc         = x_q;
    assign yloc         = y_q;
    assign pacman_dir   = dir_q;
    assign pacman_alive = alive_q;
    assign lives_left   = lives_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_pacman_motion.sv
// -----------------------------------------------------------------------------
// tb_pacman_motion
// Directed scenarios for pacman_motion with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pacman_motion;
    import pacman_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       req_valid;
    dir_t       req_dir;
    logic       kill;
    logic [8:0] xloc, yloc;
    dir_t       pacman_dir;
    logic       pacman_alive;
    logic [1:0] animation_cycle;
    logic [1:0] lives_left;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    pacman_probe_if pif ();

    pacman_motion dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .req_valid       (req_valid),
        .req_dir         (req_dir),
        .kill            (kill),
        .probe           (pif),
        .xloc            (xloc),
        .yloc            (yloc),
        .pacman_dir      (pacman_dir),
        .pacman_alive    (pacman_alive),
        .animation_cycle (animation_cycle),
        .lives_left      (lives_left),
        .game_over       (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers (all start/end just after a negedge)
    task automatic do_reset();
        rst_n           = 1'b0;
        frame_tick      = 1'b0;
        req_valid       = 1'b0;
        req_dir         = DIR_RT;
        kill            = 1'b0;
        pif.probe_ready = 1'b1;
        pif.probe_wall  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic frame();
        pulse_tick();
        repeat (5) @(negedge clk);
    endtask

    task automatic dying_tick();
        pulse_tick();
        @(negedge clk);
    endtask

    task automatic request(input dir_t d);
        req_valid = 1'b1;
        req_dir   = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pulse_kill();
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
    endtask

    task automatic wait_probe(input string name);
        int n = 0;
        while (!pif.probe_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pif.probe_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_probe_timeout: probe_valid=%b required 1", name, pif.probe_valid);
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        do_reset();
        checks++; if ({xloc, yloc} !== {9'd116, 9'd188}) begin errors++;
            $display("FAIL reset_pos: got (%0d,%0d) required (116,188)", xloc, yloc); end
        checks++; if (pacman_dir !== DIR_LT) begin errors++;
            $display("FAIL reset_dir: got %0d required 3", pacman_dir); end
        checks++; if (animation_cycle !== 2'd0) begin errors++;
            $display("FAIL reset_anim: got %0d required 0", animation_cycle); end
        checks++; if ({pacman_alive, lives_left, game_over} !== {1'b1, 2'd3, 1'b0}) begin errors++;
            $display("FAIL reset_status: alive=%b lives=%0d over=%b required 1,3,0",
                     pacman_alive, lives_left, game_over); end
        checks++; if ({pif.probe_valid, pif.probe_tx, pif.probe_ty} !== 11'd0) begin errors++;
            $display("FAIL reset_probe: valid=%b tx=%0d ty=%0d required 0,0,0",
                     pif.probe_valid, pif.probe_tx, pif.probe_ty); end
    endtask

    task automatic test_free_path();
        int exp_anim[8] = '{0, 0, 1, 1, 2, 2, 1, 1};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            checks++; if (animation_cycle !== 2'(exp_anim[k])) begin errors++;
                $display("FAIL free_anim[%0d]: got %0d required %0d", k, animation_cycle, exp_anim[k]); end
            frame();
            checks++; if (xloc !== 9'(115 - k) || yloc !== 9'd188 || pacman_dir !== DIR_LT) begin errors++;
                $display("FAIL free_pos[%0d]: got x=%0d y=%0d dir=%0d required x=%0d y=188 dir=3",
                         k, xloc, yloc, pacman_dir, 115 - k); end
        end
    endtask

    task automatic test_buffered_turn();
        do_reset();
        request(DIR_RT);
        frame();
        frame();
        checks++; if (xloc !== 9'd118 || pacman_dir !== DIR_RT) begin errors++;
            $display("FAIL turn_reverse: got x=%0d dir=%0d required x=118 dir=0", xloc, pacman_dir); end
        request(DIR_LT);
        frame();
        checks++; if (xloc !== 9'd117 || pacman_dir !== DIR_LT) begin errors++;
            $display("FAIL turn_back: got x=%0d dir=%0d required x=117 dir=3", xloc, pacman_dir); end
        // UP latched while unaligned: keep going left.
        request(DIR_UP);
        frame();
        checks++; if (xloc !== 9'd116 || yloc !== 9'd188 || pacman_dir !== DIR_LT) begin errors++;
            $display("FAIL turn_buffered: got x=%0d y=%0d dir=%0d required 116,188,3",
                     xloc, yloc, pacman_dir); end
        // Aligned in tile (14,23): the turn probe looks up at (14,22).
        pif.probe_ready = 1'b0;
        pulse_tick();
        wait_probe("turn");
        checks++; if (pif.probe_tx !== 5'd14 || pif.probe_ty !== 5'd22) begin errors++;
            $display("FAIL turn_probe_tile: got (%0d,%0d) required (14,22)", pif.probe_tx, pif.probe_ty); end
        pif.probe_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (pacman_dir !== DIR_UP || xloc !== 9'd116 || yloc !== 9'd187) begin errors++;
            $display("FAIL turn_taken: got dir=%0d x=%0d y=%0d required 1,116,187",
                     pacman_dir, xloc, yloc); end
        frame();
        checks++; if (yloc !== 9'd186) begin errors++;
            $display("FAIL turn_up_step: got y=%0d required 186", yloc); end
    endtask

    task automatic test_wall_block();
        do_reset();
        pif.probe_wall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            frame();
            checks++; if (xloc !== 9'd116 || yloc !== 9'd188 || animation_cycle !== 2'd0) begin errors++;
                $display("FAIL wall_hold[%0d]: got x=%0d y=%0d anim=%0d required 116,188,0",
                         k, xloc, yloc, animation_cycle); end
        end
        pif.probe_wall = 1'b0;
    endtask

    task automatic test_probe_stall();
        do_reset();
        pif.probe_ready = 1'b0;
        pulse_tick();
        wait_probe("stall");
        for (int k = 0; k < 5; k++) begin
            checks++; if (pif.probe_valid !== 1'b1 || pif.probe_tx !== 5'd13 ||
                          pif.probe_ty !== 5'd23 || xloc !== 9'd116) begin errors++;
                $display("FAIL stall_hold[%0d]: valid=%b tile=(%0d,%0d) x=%0d required 1,(13,23),116",
                         k, pif.probe_valid, pif.probe_tx, pif.probe_ty, xloc); end
            @(negedge clk);
        end
        pif.probe_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (xloc !== 9'd115) begin errors++;
            $display("FAIL stall_release: got x=%0d required 115", xloc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pif.probe_ready = 1'b0;
        pulse_tick();
        wait_probe("arst");
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pif.probe_valid !== 1'b0) begin errors++;
            $display("FAIL arst_probe: got valid=%b required 0", pif.probe_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        pif.probe_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tunnel();
        do_reset();
        repeat (112) frame();
        checks++; if (xloc !== 9'd4) begin errors++;
            $display("FAIL tunnel_approach: got x=%0d required 4", xloc); end
        // Tile column 0 heading left probes the far column.
        pif.probe_ready = 1'b0;
        pulse_tick();
        wait_probe("tunnel");
        checks++; if (pif.probe_tx !== 5'd27 || pif.probe_ty !== 5'd23) begin errors++;
            $display("FAIL tunnel_probe: got (%0d,%0d) required (27,23)", pif.probe_tx, pif.probe_ty); end
        pif.probe_ready = 1'b1;
        repeat (4) @(negedge clk);
        repeat (3) frame();
        checks++; if (xloc !== 9'd0) begin errors++;
            $display("FAIL tunnel_edge: got x=%0d required 0", xloc); end
        frame();
        checks++; if (xloc !== 9'd223 || pacman_dir !== DIR_LT) begin errors++;
            $display("FAIL tunnel_wrap: got x=%0d dir=%0d required 223,3", xloc, pacman_dir); end
    endtask

    task automatic test_death();
        do_reset();
        request(DIR_RT);
        repeat (8) frame();
        checks++; if (xloc !== 9'd124 || pacman_dir !== DIR_RT) begin errors++;
            $display("FAIL death_setup: got x=%0d dir=%0d required 124,0", xloc, pacman_dir); end
        pif.probe_ready = 1'b0;
        pulse_tick();
        wait_probe("death");
        checks++; if (pif.probe_tx !== 5'd16 || pif.probe_ty !== 5'd23) begin errors++;
            $display("FAIL death_probe_tile: got (%0d,%0d) required (16,23)", pif.probe_tx, pif.probe_ty); end
        pulse_kill();
        checks++; if (pif.probe_valid !== 1'b0 || pacman_alive !== 1'b0 || lives_left !== 2'd2) begin errors++;
            $display("FAIL death_enter: valid=%b alive=%b lives=%0d required 0,0,2",
                     pif.probe_valid, pacman_alive, lives_left); end
        checks++; if (xloc !== 9'd124 || pacman_dir !== DIR_RT || animation_cycle !== 2'd0) begin errors++;
            $display("FAIL death_freeze: x=%0d dir=%0d anim=%0d required 124,0,0",
                     xloc, pacman_dir, animation_cycle); end
        pif.probe_ready = 1'b1;
        pulse_kill();
        checks++; if (lives_left !== 2'd2) begin errors++;
            $display("FAIL death_kill_ignored: lives=%0d required 2", lives_left); end
        repeat (89) dying_tick();
        checks++; if (pacman_alive !== 1'b0) begin errors++;
            $display("FAIL death_89: alive=%b required 0", pacman_alive); end
        dying_tick();
        checks++; if (xloc !== 9'd116 || yloc !== 9'd188 || pacman_dir !== DIR_LT ||
                      pacman_alive !== 1'b1 || lives_left !== 2'd2) begin errors++;
            $display("FAIL death_respawn: x=%0d y=%0d dir=%0d alive=%b lives=%0d required 116,188,3,1,2",
                     xloc, yloc, pacman_dir, pacman_alive, lives_left); end

        pulse_kill();
        checks++; if (lives_left !== 2'd1 || pacman_alive !== 1'b0) begin errors++;
            $display("FAIL death2_enter: lives=%0d alive=%b required 1,0", lives_left, pacman_alive); end
        repeat (90) dying_tick();
        checks++; if (pacman_alive !== 1'b1 || game_over !== 1'b0) begin errors++;
            $display("FAIL death2_respawn: alive=%b over=%b required 1,0", pacman_alive, game_over); end

        pulse_kill();
        checks++; if (lives_left !== 2'd0) begin errors++;
            $display("FAIL death3_enter: lives=%0d required 0", lives_left); end
        repeat (90) dying_tick();
        checks++; if (game_over !== 1'b1 || pacman_alive !== 1'b0) begin errors++;
            $display("FAIL game_over: over=%b alive=%b required 1,0", game_over, pacman_alive); end

        request(DIR_RT);
        pulse_kill();
        repeat (3) frame();
        checks++; if (game_over !== 1'b1 || pacman_alive !== 1'b0 || xloc !== 9'd116 ||
                      lives_left !== 2'd0 || pif.probe_valid !== 1'b0) begin errors++;
            $display("FAIL over_sticky: over=%b alive=%b x=%0d lives=%0d valid=%b required 1,0,116,0,0",
                     game_over, pacman_alive, xloc, lives_left, pif.probe_valid); end
    endtask

    initial begin
        test_reset();
        test_free_path();
        test_buffered_turn();
        test_wall_block();
        test_probe_stall();
        test_async_reset();
        test_tunnel();
        test_death();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
